keypad_debouncer: RTL and testbench

KEYPAD_DEBOUNCER -- requirements
Module: keypad_debouncer

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_decoder.sv | 15 +
 rtl/keypad_debouncer.sv | 103 ++++++++++
 tb/tb_keypad_debouncer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad debouncer.
// Holds the FSM state encoding, the 4x4 key map and one-hot helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // Indexed by {row, col}; entry 0 (rightmost) is row 0 / col 0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Maps a scanner code (one-hot column in [7:4], one-hot row in [3:0]) to a hex digit.
// Purely combinational; valid is low unless both nibbles are one-hot.
// No flow control: output follows input in the same cycle.
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] digit,
    output logic       valid
);

    assign valid = is_onehot4(code[3:0]) && is_onehot4(code[7:4]);
    assign digit = KEY_MAP[{onehot_index(code[3:0]), onehot_index(code[7:4])}];

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces keypad presses/releases and emits one keyvalid pulse per accepted key.
// Latency: keyvalid rises DEBOUNCE_CYCLES cycles after the press is captured.
// Backpressure: none; stopscan holds the scanner still while a key is being tracked.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rowpressed,
    input  logic [7:0] currentpress,
    output logic       stopscan,
    output logic       keyvalid,
    output logic [3:0] keydigit,
    output logic [3:0] newdigit,
    output logic [3:0] olddigit
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [7:0]      presscode, presscode_nx;
    logic            accept;
    logic [3:0]      dec_digit;
    logic            dec_valid;

    keypad_decoder u_decoder (
        .code  (presscode),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        presscode_nx = presscode;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (rowpressed) begin
                    presscode_nx = currentpress;
                    cnt_nx       = '0;
                    state_nx     = DB_PRESS;
                end
            end
            DB_PRESS: begin
                // A malformed code is rejected exactly like a bounce.
                if (!rowpressed || (currentpress != presscode) || !dec_valid) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nx = HELD;
                    accept   = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!rowpressed) begin
                    cnt_nx   = '0;
                    state_nx = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (rowpressed) begin
                    state_nx = HELD;
                end else if (cnt == CNT_MAX) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            presscode <= '0;
            stopscan  <= 1'b0;
            keyvalid  <= 1'b0;
            keydigit  <= '0;
            newdigit  <= '0;
            olddigit  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            presscode <= presscode_nx;
            stopscan  <= (state_nx != IDLE);
            keyvalid  <= accept;
            if (accept) begin
                keydigit <= dec_digit;
                newdigit <= dec_digit;
                olddigit <= newdigit;
            end
        end
    end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Bench for keypad_debouncer: directed scenarios then random press/bounce traffic,
// scored against a run-length reference model through expectation queues.
module tb_keypad_debouncer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rowpressed;
    logic [7:0] currentpress;
    logic       stopscan;
    logic       keyvalid;
    logic [3:0] keydigit;
    logic [3:0] newdigit;
    logic [3:0] olddigit;

    always #5 clk = ~clk;

    keypad_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .rowpressed   (rowpressed),
        .currentpress (currentpress),
        .stopscan     (stopscan),
        .keyvalid     (keyvalid),
        .keydigit     (keydigit),
        .newdigit     (newdigit),
        .olddigit     (olddigit)
    );

    typedef struct packed {
        logic       ss;
        logic       kv;
        logic [3:0] kd;
        logic [3:0] nd;
        logic [3:0] od;
    } obs_t;

    obs_t       exp_q[$];
    logic [3:0] key_q[$];
    int         total = 0;
    int         bad   = 0;

    // Reference model: a press is accepted after N+1 consecutive identical valid
    // samples starting from idle; a release needs N+1 consecutive low samples.
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
    int         press_run = 0;
    int         zero_run  = 0;
    bit         held      = 0;
    logic [7:0] cap       = '0;
    logic [3:0] m_key = '0, m_new = '0, m_old = '0;

    function automatic bit code_ok(input logic [7:0] c);
        return ($countones(c[3:0]) == 1) && ($countones(c[7:4]) == 1);
    endfunction

    function automatic logic [3:0] digit_of(input logic [7:0] c);
        int r = 0;
        int k = 0;
        for (int i = 0; i < 4; i++) begin
            if (c[i])     r = i;
            if (c[i + 4]) k = i;
        end
        return kmap[r * 4 + k];
    endfunction

    task automatic model_edge(input bit r, input bit rp, input logic [7:0] cp);
        bit kv = 0;
        if (r) begin
            press_run = 0; zero_run = 0; held = 0; cap = '0;
            m_key = '0; m_new = '0; m_old = '0;
        end else if (held) begin
            if (rp) zero_run = 0;
            else begin
                zero_run++;
                if (zero_run == N + 1) begin
                    held = 0;
                    zero_run = 0;
                end
            end
        end else if (press_run == 0) begin
            if (rp) begin
                press_run = 1;
                cap = cp;
            end
        end else if (rp && cp == cap && code_ok(cap)) begin
            press_run++;
            if (press_run == N + 1) begin
                kv = 1;
                m_old = m_new;
                m_new = digit_of(cap);
                m_key = m_new;
                held = 1;
                press_run = 0;
                zero_run = 0;
                key_q.push_back(m_new);
            end
        end else begin
            press_run = 0;
        end
        exp_q.push_back('{ss: (held || press_run > 0), kv: kv, kd: m_key, nd: m_new, od: m_old});
    endtask

    task automatic step(input bit r, input bit rp, input logic [7:0] cp);
        reset = r;
        rowpressed = rp;
        currentpress = cp;
        @(posedge clk);
        model_edge(r, rp, cp);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input bit rp, input logic [7:0] cp);
        for (int i = 0; i < n; i++) step(1'b0, rp, cp);
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        logic [3:0] k;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{ss: stopscan, kv: keyvalid, kd: keydigit, nd: newdigit, od: olddigit};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs t=%0t got ss=%b kv=%b kd=%h nd=%h od=%h, want ss=%b kv=%b kd=%h nd=%h od=%h",
                         $time, a.ss, a.kv, a.kd, a.nd, a.od, e.ss, e.kv, e.kd, e.nd, e.od);
            end
            if (keyvalid === 1'b1) begin
                total++;
                if (key_q.size() == 0) begin
                    bad++;
                    $display("FAIL key_pulse t=%0t got keydigit=%h, want no key", $time, keydigit);
                end else begin
                    k = key_q.pop_front();
                    if (keydigit !== k) begin
                        bad++;
                        $display("FAIL key_digit t=%0t got %h, want %h", $time, keydigit, k);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] cp;
        bit         rp;
        int         len;

        reset = 1'b1;
        rowpressed = 1'b0;
        currentpress = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        hold(3, 1'b0, 8'h00);

        hold(10, 1'b1, 8'h42);      // clean press: key 6
        hold(10, 1'b0, 8'h00);

        hold(2, 1'b1, 8'h42);       // bounce
        hold(6, 1'b0, 8'h00);

        hold(10, 1'b1, 8'h84);      // key C, old 6
        hold(10, 1'b0, 8'h00);

        hold(8, 1'b1, 8'h11);       // release glitch inside HELD
        hold(2, 1'b0, 8'h00);
        hold(4, 1'b1, 8'h11);
        hold(10, 1'b0, 8'h00);

        hold(10, 1'b1, 8'h63);      // malformed code
        hold(4, 1'b0, 8'h00);

        hold(7, 1'b1, 8'h28);       // reach HELD, then reset
        step(1'b1, 1'b1, 8'h28);
        hold(3, 1'b1, 8'h28);
        hold(8, 1'b0, 8'h00);

        for (int s = 0; s < 300; s++) begin
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 5) == 0)
                cp = 8'($urandom_range(0, 255));
            else
                cp = {4'b0001 << $urandom_range(0, 3), 4'b0001 << $urandom_range(0, 3)};
            rp = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 99) == 0)
                    step(1'b1, rp, cp);
                else if ($urandom_range(0, 9) == 0)
                    step(1'b0, !rp, cp);
                else
                    step(1'b0, rp, cp);
            end
        end

        hold(12, 1'b0, 8'h00);
        #1;
        total++;
        if (key_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got keys_left=%0d exp_left=%0d, want 0 and 0", key_q.size(), exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
